iir_out_decimator: RTL
======================

IIR_OUT_DECIMATOR -- requirements
Module: iir_out_decimator

Interface
REQ-001 Parameter DECIM, default 4, decimation factor; legal values 2, 4, 8, 16.
REQ-002 Parameter OUT_W, default 12, output word width; legal range 8..16.
REQ-003 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port reset_n, input, 1, asynchronous active-low reset.
REQ-005 Port data_in, input, 17, signed filter output in Q2.15 (bits [1:-15]).
REQ-006 Port sample_en, input, 1, data_in holds a valid filter sample this cycle.
REQ-007 Port data_out, output, OUT_W, signed averaged sample in Q2.(OUT_W-2).
REQ-008 Port out_valid, output, 1, data_out holds the FIFO head.
REQ-009 Port out_ready, input, 1, consumer accepts the head when out_valid is also high.
REQ-010 Port ovf, output, 1, sticky flag: a result was dropped because the FIFO was full.
REQ-011 Port clr_ovf, input, 1, synchronous clear of ovf.

Function
REQ-012 Phase counter (0..DECIM-1) and accumulator (17+log2(DECIM) bits, signed) SHALL advance only on cycles with sample_en=1.
REQ-013 On sample_en with phase<DECIM-1: acc <= acc + data_in, phase <= phase+1.
REQ-014 On sample_en with phase=DECIM-1: result computed from sum = acc + data_in; acc <= 0; phase <= 0; result pushed into FIFO at the same edge.
REQ-015 Scaling: shift S = log2(DECIM) + (17-OUT_W); result = (sum + 2^(S-1)) >>> S (round half up, arithmetic shift).
REQ-016 Saturation: result clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; no wrap-around permitted.
REQ-017 Latency: out_valid SHALL rise the cycle after the edge that captures the DECIM-th sample when the FIFO was empty; no combinational bypass.
REQ-018 FIFO: 4 entries, first-in first-out; pop occurs on an edge where out_valid=1 and out_ready=1.
REQ-019 out_valid = FIFO not empty; data_out = FIFO head, held stable while out_valid=1 and out_ready=0.
REQ-020 Push when full without a simultaneous pop: result dropped, FIFO unchanged, ovf <= 1.
REQ-021 Push when full with a simultaneous pop: both accepted, occupancy stays 4, no overflow.
REQ-022 Push and pop on the same edge at any other occupancy: both accepted, occupancy unchanged.
REQ-023 clr_ovf together with a new overflow event: ovf stays 1 (set wins).
REQ-024 sample_en=0 cycles SHALL not alter acc, phase or ordering; gaps of any length are legal.

Reset
REQ-025 On reset_n=0, asynchronously: acc=0, phase=0, FIFO empty, out_valid=0, data_out=0, ovf=0.
REQ-026 A reset mid-accumulation SHALL discard the partial sum; the first sample after release starts phase 0.
REQ-027 Reset release is synchronous to clk; the first sample_en is honoured on the first edge with reset_n=1.

Structure
REQ-028 Shared package iir_pkg SHALL hold IN_W=17, IN_FRAC=15, FIFO_DEPTH=4 and the legal-DECIM check.
REQ-029 The FIFO SHALL be a sub-module dec_fifo (parameterised width, depth 4, full/empty/count outputs).
REQ-030 The rounding/saturation datapath is combinational in the top and feeds the dec_fifo write port directly.

Verification (DECIM=4, OUT_W=12, S=7)
REQ-031 Four samples of 0x08000 (1.0), out_ready=1 -> one output 0x400 (1.0), out_valid high for exactly one cycle.
REQ-032 Four samples of 0x0FFFF -> raw 2048, saturated to 0x7FF; four samples of 0x10000 -> 0x800, no saturation.
REQ-033 Rounding: samples {64,0,0,0} -> 0x001; samples {63,0,0,0} -> 0x000; samples {-64,0,0,0} -> 0x000.
REQ-034 out_ready=0, 20 samples of 0x08000 -> FIFO holds four 0x400, fifth result dropped, ovf=1; clr_ovf -> ovf=0; raising out_ready drains exactly 4 words.
REQ-035 Two samples, then reset_n pulse, then four samples of 0x08000 -> exactly one output 0x400 (partial sum discarded).
REQ-036 Random sample_en gaps and out_ready back-pressure against a reference model -> output sequence bit-exact, no loss unless ovf asserted.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared constants for the IIR output decimator: input format, FIFO depth and
// the check that DECIM is a supported decimation factor.
package iir_pkg;
  localparam int IN_W       = 17;
  localparam int IN_FRAC    = 15;
  localparam int FIFO_DEPTH = 4;

  function automatic bit decim_legal(input int d);
    return (d == 2) || (d == 4) || (d == 8) || (d == 16);
  endfunction
endpackage

// File: rtl/dec_fifo.sv
// Small synchronous FIFO. The read data is the registered head, so nothing
// pushed at an edge is visible before the following cycle.
module dec_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/iir_out_decimator.sv
// Averages DECIM consecutive Q2.15 filter samples, rounds and saturates the
// mean to Q2.(OUT_W-2), and queues results in a 4-entry output FIFO.
module iir_out_decimator import iir_pkg::*; #(
  parameter int DECIM = 4,
  parameter int OUT_W = 12
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic signed [IN_W-1:0] data_in,
  input  logic                   sample_en,
  output logic [OUT_W-1:0]       data_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   ovf,
  input  logic                   clr_ovf
);
  localparam int LD = $clog2(DECIM);
  localparam int AW = IN_W + LD;
  localparam int S  = LD + IN_W - OUT_W;
  localparam int RW = AW + 1;
  localparam logic signed [RW-1:0] MAXV = RW'((1 << (OUT_W-1)) - 1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  if (!decim_legal(DECIM) || OUT_W < 8 || OUT_W > 16) begin : g_bad_param
    $error("iir_out_decimator: unsupported DECIM or OUT_W");
  end

  logic signed [AW-1:0]    acc, sum;
  logic [LD-1:0]           phase;
  logic signed [RW-1:0]    biased, shifted;
  logic signed [OUT_W-1:0] result;
  logic                    last, push, pop, full, empty;
  logic [$clog2(FIFO_DEPTH+1)-1:0] unused_count;

  assign last = (phase == LD'(DECIM-1));
  assign push = sample_en && last;
  assign sum  = acc + {{LD{data_in[IN_W-1]}}, data_in};

  // One guard bit keeps the half-LSB bias from overflowing at full-scale positive sums.
  always_comb begin
    biased  = {sum[AW-1], sum} + (RW'(1) << (S-1));
    shifted = biased >>> S;
    if (shifted > MAXV)      result = MAXV[OUT_W-1:0];
    else if (shifted < MINV) result = MINV[OUT_W-1:0];
    else                     result = shifted[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc   <= '0;
      phase <= '0;
    end else if (sample_en) begin
      acc   <= last ? '0 : sum;
      phase <= last ? '0 : phase + LD'(1);
    end
  end

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  // Set wins over clear so an overflow coinciding with clr_ovf is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                ovf <= 1'b0;
    else if (push && full && !pop) ovf <= 1'b1;
    else if (clr_ovf)            ovf <= 1'b0;
  end

  dec_fifo #(.WIDTH(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (result),
    .pop     (pop),
    .rdata   (data_out),
    .full    (full),
    .empty   (empty),
    .count   (unused_count)
  );
endmodule
